clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clkdiv_if.sv | 14 +
 rtl/clkdiv_rr_arbiter.sv | 46 ++++
 rtl/clkdiv_ctrl.sv | 136 +++++++++++++
 tb/tb_clkdiv_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and default parameters for the clock-divider controller slice.
package clkdiv_pkg;

    localparam int CNT_W   = 8;
    localparam int N_REQ   = 4;
    localparam int DIV_RST = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/clkdiv_if.sv
// Divide-ratio configuration handshake between a host and the divider controller.
interface clkdiv_if #(
    parameter int CNT_W = clkdiv_pkg::CNT_W
) ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/clkdiv_rr_arbiter.sv
// Round-robin grant selector; the pointer moves only when a grant is actually issued.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t ptr_q;
    ptr_t sel;
    ptr_t idx;
    logic found;

    // NOTE: every variable gets a default before the search loop, otherwise
    // the paths where no request matches would infer latches.
    always_comb begin
        gnt   = '0;
        sel   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr_t'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                sel      = idx;
            end
        end
    end

    // Reset to the last index so that requester 0 wins the first grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ptr_t'(N_REQ - 1);
        end else if (advance && found) begin
            ptr_q <= sel;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with start/stop/drain control, glitch-free ratio
// updates at half-period boundaries, and a round-robin tick grant.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = clkdiv_pkg::CNT_W,
    parameter int N_REQ   = clkdiv_pkg::N_REQ,
    parameter int DIV_RST = clkdiv_pkg::DIV_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    clkdiv_if.slave          cfg,
    input  logic [N_REQ-1:0] req,
    output logic             clk2,
    output logic             tick,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    typedef logic [CNT_W-1:0] cnt_t;

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    cnt_t   div_q, div_d;
    cnt_t   pend_div_q, pend_div_d;
    logic   pend_q, pend_d;
    logic   clk2_d, tick_d, err_d, busy_d;
    logic   err_q, ready_q;
    logic   xfer, terminal;
    logic [N_REQ-1:0] gnt_c;

    assign xfer          = cfg.cfg_valid & ready_q;
    assign terminal      = (cnt_q == div_q - cnt_t'(1));
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (tick_d),
        .gnt     (gnt_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk2_d     = clk2;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN, DRAIN: begin
                if (state_q == RUN && stop && !clk2) begin
                    // Already low: stop cleanly without emitting a tick.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    clk2_d = ~clk2;
                    tick_d = 1'b1;
                    if (clk2 && (state_q == DRAIN || stop)) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                    if (state_q == RUN && stop) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A held ratio lands on a half-period boundary or once the divider is idle.
        if (pend_q && (tick_d || state_q == IDLE || state_d == IDLE)) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
        end

        if (xfer) begin
            if (cfg.cfg_div == '0) begin
                err_d = 1'b1;
            end else if (state_q == IDLE) begin
                div_d = cfg.cfg_div;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = cfg.cfg_div;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clk2       <= 1'b0;
            tick       <= 1'b0;
            gnt        <= '0;
            err_q      <= 1'b0;
            busy       <= 1'b0;
            div_q      <= cnt_t'(DIV_RST);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk2       <= clk2_d;
            tick       <= tick_d;
            gnt        <= tick_d ? gnt_c : '0;
            err_q      <= err_d;
            busy       <= busy_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            ready_q    <= ~pend_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: each step advances whole clocks, then
// compares outputs 1 time unit after the rising edge.
module tb_clkdiv_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] req;
    logic       clk2;
    logic       tick;
    logic [3:0] gnt;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    clkdiv_if cfg_bus ();

    clkdiv_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .cfg   (cfg_bus),
        .req   (req),
        .clk2  (clk2),
        .tick  (tick),
        .gnt   (gnt),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        stop              = 1'b0;
        req               = '0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        step(2);
        check("rst_clk2",  clk2, 0);
        check("rst_tick",  tick, 0);
        check("rst_gnt",   gnt, 0);
        check("rst_busy",  busy, 0);
        check("rst_ready", cfg_bus.cfg_ready, 1);
        check("rst_err",   cfg_bus.cfg_err, 0);
        rst_n = 1'b1;
        step(1);

        // Reset ratio 2: toggles 2, 4 edges after entering RUN.
        start = 1'b1;
        step(1);
        check("run_busy", busy, 1);
        check("run_e0_clk2", clk2, 0);
        start = 1'b0;
        step(1);
        check("run_e1_tick", tick, 0);
        step(1);
        check("run_e2_clk2", clk2, 1);
        check("run_e2_tick", tick, 1);
        step(1);
        check("run_e3_tick", tick, 0);
        step(1);
        check("run_e4_clk2", clk2, 0);
        check("run_e4_tick", tick, 1);

        // Ratio 5 offered mid half-period, held until the next terminal count.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd5;
        step(1);
        check("pend_ready_low", cfg_bus.cfg_ready, 0);
        check("pend_e5_tick", tick, 0);
        cfg_bus.cfg_valid = 1'b0;
        step(1);
        check("pend_e6_clk2", clk2, 1);
        check("pend_e6_tick", tick, 1);
        check("pend_ready_back", cfg_bus.cfg_ready, 1);
        step(4);
        check("div5_hold_tick", tick, 0);
        check("div5_hold_clk2", clk2, 1);
        step(1);
        check("div5_toggle_tick", tick, 1);
        check("div5_toggle_clk2", clk2, 0);

        // Illegal ratio 0: error pulse, period stays 5.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd0;
        step(1);
        check("zero_err_pulse", cfg_bus.cfg_err, 1);
        check("zero_ready", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b0;
        step(1);
        check("zero_err_clear", cfg_bus.cfg_err, 0);
        step(2);
        check("zero_period_hold", tick, 0);
        step(1);
        check("zero_period_tick", tick, 1);
        check("zero_period_clk2", clk2, 1);

        // Stop while high: drain to the falling toggle; start in DRAIN ignored.
        stop = 1'b1;
        step(1);
        check("drain_busy", busy, 1);
        check("drain_clk2", clk2, 1);
        check("drain_tick", tick, 0);
        stop  = 1'b0;
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(1);
        check("drain_e20_clk2", clk2, 1);
        check("drain_e20_busy", busy, 1);
        step(1);
        check("drain_end_clk2", clk2, 0);
        check("drain_end_tick", tick, 1);
        check("drain_end_busy", busy, 0);
        step(1);
        check("idle_tick", tick, 0);
        check("idle_busy", busy, 0);

        // Ratio 2 loaded in IDLE; start+stop together keeps IDLE.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd2;
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        check("startstop_idle", busy, 0);
        stop = 1'b0;
        step(1);
        start = 1'b0;
        check("restart_busy", busy, 1);
        step(1);
        check("restart_e1_tick", tick, 0);
        step(1);
        check("restart_e2_clk2", clk2, 1);
        check("restart_e2_tick", tick, 1);
        step(2);
        check("restart_e4_clk2", clk2, 0);

        // Stop while low: IDLE next edge, no tick.
        stop = 1'b1;
        step(1);
        check("stoplow_busy", busy, 0);
        check("stoplow_tick", tick, 0);
        check("stoplow_clk2", clk2, 0);
        stop = 1'b0;
        step(1);
        check("stoplow_hold_tick", tick, 0);
        check("stoplow_hold_clk2", clk2, 0);

        // Round-robin grants at ticks with req=1011.
        req   = 4'b1011;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check("rr_gnt1", gnt, 4'b0001);
        step(1);
        check("rr_gap", gnt, 4'b0000);
        step(1);
        check("rr_gnt2", gnt, 4'b0010);
        step(2);
        check("rr_gnt3", gnt, 4'b1000);
        step(2);
        check("rr_gnt4", gnt, 4'b0001);
        req = 4'b0000;
        step(2);
        check("rr_noreq_tick", tick, 1);
        check("rr_noreq_gnt", gnt, 4'b0000);
        req = 4'b1011;
        step(2);
        check("rr_ptr_held", gnt, 4'b0010);

        // Ratio 1: toggle every cycle.
        req  = 4'b0000;
        stop = 1'b1;
        step(1);
        stop              = 1'b0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd1;
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("div1_e1_clk2", clk2, 1);
        check("div1_e1_tick", tick, 1);
        step(1);
        check("div1_e2_clk2", clk2, 0);
        check("div1_e2_tick", tick, 1);
        step(1);
        check("div1_e3_clk2", clk2, 1);

        // Largest ratio 255 taken as pending at ratio 1.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd255;
        step(1);
        check("max_ready_low", cfg_bus.cfg_ready, 0);
        check("max_e1_clk2", clk2, 0);
        cfg_bus.cfg_valid = 1'b0;
        step(1);
        check("max_apply_clk2", clk2, 1);
        check("max_ready_back", cfg_bus.cfg_ready, 1);
        step(254);
        check("max_hold_tick", tick, 0);
        check("max_hold_clk2", clk2, 1);
        step(1);
        check("max_toggle_tick", tick, 1);
        check("max_toggle_clk2", clk2, 0);

        // Asynchronous reset mid-RUN with a pending ratio.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd7;
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        check("arst_pre_ready", cfg_bus.cfg_ready, 0);
        check("arst_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_clk2", clk2, 0);
        check("arst_ready", cfg_bus.cfg_ready, 1);
        check("arst_tick", tick, 0);
        step(1);
        rst_n = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("arst_div_e1_tick", tick, 0);
        step(1);
        check("arst_div_e2_tick", tick, 1);
        check("arst_div_e2_clk2", clk2, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
